// File: rtl/cspec_pkg.sv
// Shared definitions for the speculative-adder recovery stage.
package cspec_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;

    localparam logic ST_PASS    = 1'b0;
    localparam logic ST_CORRECT = 1'b1;

    typedef enum logic {
        S_PASS    = ST_PASS,
        S_CORRECT = ST_CORRECT
    } state_t;

endpackage

// File: rtl/cspec_exact_add.sv
// Combinational exact adder: {cout,sum} = a + b + cin.
module cspec_exact_add
    import cspec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/cspec_recovery.sv
// Recovery stage behind the speculative adder: passes correct speculation through in one
// cycle, recomputes mis-speculated results in a single correction cycle, and keeps
// saturating operation / error counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_PASS    | accepting ops; good speculation goes straight to the output regs
// S_CORRECT | upstream stalled; fix regs hold the operands to be recomputed
module cspec_recovery
    import cspec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_spec_sum,
    input  logic             in_spec_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] fix_a;
    logic [WIDTH-1:0] fix_b;
    logic             fix_cin;

    logic [WIDTH-1:0] det_sum;
    logic             det_cout;
    logic [WIDTH-1:0] cor_sum;
    logic             cor_cout;

    logic             err;
    logic             free;
    logic             accept;

    // Detection path: exact result of the live inputs.
    cspec_exact_add #(.WIDTH(WIDTH)) u_detect (
        .a    (in_a),
        .b    (in_b),
        .cin  (in_cin),
        .sum  (det_sum),
        .cout (det_cout)
    );

    // Correction path: exact result of the captured operands.
    cspec_exact_add #(.WIDTH(WIDTH)) u_correct (
        .a    (fix_a),
        .b    (fix_b),
        .cin  (fix_cin),
        .sum  (cor_sum),
        .cout (cor_cout)
    );

    assign err      = ({in_spec_cout, in_spec_sum} != {det_cout, det_sum});
    assign free     = !out_valid || out_ready;
    assign in_ready = (state == S_PASS) && free;
    assign accept   = in_valid && in_ready;

    // FSM and output registers; a load in the same cycle overrides the handshake drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_PASS;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
            fix_a     <= '0;
            fix_b     <= '0;
            fix_cin   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_PASS: begin
                    if (accept) begin
                        if (err) begin
                            fix_a   <= in_a;
                            fix_b   <= in_b;
                            fix_cin <= in_cin;
                            state   <= S_CORRECT;
                        end else begin
                            out_valid <= 1'b1;
                            out_sum   <= in_spec_sum;
                            out_cout  <= in_spec_cout;
                            out_err   <= 1'b0;
                        end
                    end
                end
                S_CORRECT: begin
                    if (free) begin
                        out_valid <= 1'b1;
                        out_sum   <= cor_sum;
                        out_cout  <= cor_cout;
                        out_err   <= 1'b1;
                        state     <= S_PASS;
                    end
                end
                default: state <= S_PASS;
            endcase
        end
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            if (op_cnt != CNT_MAX) begin
                op_cnt <= op_cnt + CNT_W'(1);
            end
            if (err && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cspec_recovery.sv
// Self-checking bench for cspec_recovery: directed scenarios plus a randomized run against
// an arithmetic reference model (expected-result queue and saturating counts).
module tb_cspec_recovery;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [15:0] in_spec_sum = '0;
    logic        in_spec_cout = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_cnt = 1'b0;

    logic        in_ready, out_valid, out_cout, out_err;
    logic [15:0] out_sum, op_cnt, err_cnt;
    logic        in_ready2, out_valid2, out_cout2, out_err2;
    logic [15:0] out_sum2;
    logic [1:0]  op_cnt2, err_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cspec_recovery #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_spec_sum(in_spec_sum),
        .in_spec_cout(in_spec_cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err), .clr_cnt(clr_cnt),
        .op_cnt(op_cnt), .err_cnt(err_cnt)
    );

    cspec_recovery #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_spec_sum(in_spec_sum),
        .in_spec_cout(in_spec_cout), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_cout(out_cout2), .out_err(out_err2), .clr_cnt(clr_cnt),
        .op_cnt(op_cnt2), .err_cnt(err_cnt2)
    );

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        return 17'(a) + 17'(b) + 17'(cin);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [16:0] spec);
        in_a = a; in_b = b; in_cin = cin;
        {in_spec_cout, in_spec_sum} = spec;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        drive(16'h1111, 16'h2222, 1'b0, 17'h03333);
        tick(); settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if (out_sum !== 16'h0) begin fails++; $display("FAIL reset_sum got %h want 0000", out_sum); end
        tests++; if ({out_cout, out_err} !== 2'b00) begin fails++; $display("FAIL reset_cout_err got %b want 00", {out_cout, out_err}); end
        tests++; if ({op_cnt, err_cnt} !== 32'h0) begin fails++; $display("FAIL reset_cnt got %h/%h want 0/0", op_cnt, err_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        in_valid = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_pass();
        do_reset();
        drive(16'h1234, 16'h0101, 1'b0, 17'h01335);
        settle();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL pass_in_ready got %b want 1", in_ready); end
        tick(); in_valid = 1'b0; settle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pass_valid got %b want 1", out_valid); end
        tests++; if ({out_cout, out_sum} !== 17'h01335) begin fails++; $display("FAIL pass_result got %h want 01335", {out_cout, out_sum}); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL pass_err got %b want 0", out_err); end
        tests++; if (op_cnt !== 16'd1 || err_cnt !== 16'd0) begin fails++; $display("FAIL pass_cnt got %0d/%0d want 1/0", op_cnt, err_cnt); end
    endtask

    task automatic test_correct(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic [16:0] spec,
                                input logic [16:0] want);
        do_reset();
        drive(a, b, cin, spec);
        settle();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_accept got %b want 1", name, in_ready); end
        tick(); in_valid = 1'b0; settle();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL %s_stall got %b want 0", name, in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_early_valid got %b want 0", name, out_valid); end
        tick(); settle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_valid got %b want 1", name, out_valid); end
        tests++; if ({out_cout, out_sum} !== want) begin fails++; $display("FAIL %s_result got %h want %h", name, {out_cout, out_sum}, want); end
        tests++; if (out_err !== 1'b1) begin fails++; $display("FAIL %s_err got %b want 1", name, out_err); end
        tests++; if (op_cnt !== 16'd1 || err_cnt !== 16'd1) begin fails++; $display("FAIL %s_cnt got %0d/%0d want 1/1", name, op_cnt, err_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_resume got %b want 1", name, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q[3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] a, b;
            a = 16'($urandom); b = 16'($urandom);
            exp_q[k] = ref_add(a, b, k[0]);
            drive(a, b, k[0], exp_q[k]);
            settle();
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d] got %b want 1", k, in_ready); end
            if (k > 0) begin
                tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp_q[k-1]) begin fails++; $display("FAIL b2b_out[%0d] got v=%b %h want v=1 %h", k-1, out_valid, {out_cout, out_sum}, exp_q[k-1]); end
            end
            tick();
        end
        in_valid = 1'b0; settle();
        tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp_q[2]) begin fails++; $display("FAIL b2b_out[2] got v=%b %h want v=1 %h", out_valid, {out_cout, out_sum}, exp_q[2]); end
        tick(); settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drop got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [16:0] e1, e2, e3;
        do_reset();
        e1 = ref_add(16'hA5A5, 16'h1111, 1'b1);
        e2 = ref_add(16'h8000, 16'h8000, 1'b0);
        e3 = ref_add(16'h0F0F, 16'h00F1, 1'b1);
        out_ready = 1'b0;
        drive(16'hA5A5, 16'h1111, 1'b1, e1);
        tick();
        drive(16'h8000, 16'h8000, 1'b0, e2);
        for (int i = 0; i < 5; i++) begin
            settle();
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
            tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== e1 || out_err !== 1'b0) begin fails++; $display("FAIL stall_hold[%0d] got v=%b %h e=%b want v=1 %h e=0", i, out_valid, {out_cout, out_sum}, out_err, e1); end
            tick();
        end
        out_ready = 1'b1; settle();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release got %b want 1", in_ready); end
        tick(); in_valid = 1'b0; settle();
        tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== e2) begin fails++; $display("FAIL stall_second got v=%b %h want v=1 %h", out_valid, {out_cout, out_sum}, e2); end
        tick();
        out_ready = 1'b0;
        drive(16'h0F0F, 16'h00F1, 1'b1, e3 ^ 17'h00100);
        tick(); in_valid = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== e3 || out_err !== 1'b1) begin fails++; $display("FAIL stall_fix_hold[%0d] got v=%b %h e=%b want v=1 %h e=1", i, out_valid, {out_cout, out_sum}, out_err, e3); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_fix_ready[%0d] got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1; tick(); settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_fix_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_in_correct();
        do_reset();
        drive(16'h00FF, 16'h0001, 1'b0, 17'h00000);
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstcor_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstcor_state got in_ready=%b want 1", in_ready); end
        tests++; if (op_cnt !== 16'd0 || err_cnt !== 16'd0) begin fails++; $display("FAIL rstcor_cnt got %0d/%0d want 0/0", op_cnt, err_cnt); end
        tick(); settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstcor_dropped got %b want 0", out_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(16'(k * 7), 16'h0003, 1'b0, ref_add(16'(k * 7), 16'h0003, 1'b0));
            tick();
        end
        in_valid = 1'b0; settle();
        tests++; if (op_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_op_cnt2 got %0d want 3", op_cnt2); end
        tests++; if (op_cnt !== 16'd4) begin fails++; $display("FAIL sat_op_cnt got %0d want 4", op_cnt); end
        drive(16'h0001, 16'h0002, 1'b0, 17'h00003);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0; in_valid = 1'b0; settle();
        tests++; if (op_cnt !== 16'd0 || op_cnt2 !== 2'd0) begin fails++; $display("FAIL clr_over_inc got %0d/%0d want 0/0", op_cnt, op_cnt2); end
        tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== 17'h00003) begin fails++; $display("FAIL clr_op_result got v=%b %h want v=1 00003", out_valid, {out_cout, out_sum}); end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] item;
        logic [16:0] ex, spec;
        logic        holding, stall_prev, pending_fix, exp_ready, acc, e;
        logic [17:0] saved;
        int          n_op, n_err;
        localparam int N = 600;
        do_reset();
        holding = 0; stall_prev = 0; pending_fix = 0; n_op = 0; n_err = 0; saved = '0;
        for (int i = 0; i < N; i++) begin
            if (!holding) begin
                in_valid = (i < N - 20) && ($urandom_range(0, 3) != 0);
                in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
                ex = ref_add(in_a, in_b, in_cin);
                spec = ($urandom_range(0, 2) == 0) ? (ex ^ (17'd1 << $urandom_range(0, 16))) : ex;
                {in_spec_cout, in_spec_sum} = spec;
            end
            out_ready = (i >= N - 20) || ($urandom_range(0, 3) != 0);
            clr_cnt = ($urandom_range(0, 49) == 0);
            settle();
            tests++; if (op_cnt !== 16'((n_op > 65535) ? 65535 : n_op) || err_cnt !== 16'((n_err > 65535) ? 65535 : n_err)) begin fails++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, op_cnt, err_cnt, n_op, n_err); end
            tests++; if (op_cnt2 !== 2'((n_op > 3) ? 3 : n_op) || err_cnt2 !== 2'((n_err > 3) ? 3 : n_err)) begin fails++; $display("FAIL rnd_cnt2[%0d] got %0d/%0d want sat(%0d)/sat(%0d)", i, op_cnt2, err_cnt2, n_op, n_err); end
            exp_ready = !pending_fix && (!out_valid || out_ready);
            tests++; if (in_ready !== exp_ready) begin fails++; $display("FAIL rnd_in_ready[%0d] got %b want %b", i, in_ready, exp_ready); end
            if (stall_prev) begin
                tests++; if ({out_valid, out_err, out_cout, out_sum} !== {1'b1, saved}) begin fails++; $display("FAIL rnd_hold[%0d] got %h want %h", i, {out_valid, out_err, out_cout, out_sum}, {1'b1, saved}); end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rnd_unexpected[%0d] got %h want none", i, {out_err, out_cout, out_sum});
                end else begin
                    item = q.pop_front();
                    if ({out_err, out_cout, out_sum} !== item) begin fails++; $display("FAIL rnd_result[%0d] got %h want %h", i, {out_err, out_cout, out_sum}, item); end
                end
            end
            stall_prev = out_valid && !out_ready;
            saved = {out_err, out_cout, out_sum};
            if (pending_fix && (!out_valid || out_ready)) pending_fix = 0;
            acc = in_valid && in_ready;
            e = ({in_spec_cout, in_spec_sum} != ref_add(in_a, in_b, in_cin));
            if (acc) begin
                q.push_back({e, ref_add(in_a, in_b, in_cin)});
                if (e) pending_fix = 1;
            end
            holding = in_valid && !acc;
            if (clr_cnt) begin
                n_op = 0; n_err = 0;
            end else if (acc) begin
                n_op++;
                if (e) n_err++;
            end
            tick();
        end
        in_valid = 1'b0; clr_cnt = 1'b0;
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_drain got %0d left want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_correct("fix_carry", 16'h00FF, 16'h0001, 1'b0, 17'h00000, 17'h00100);
        test_correct("fix_wrap", 16'hFFFF, 16'h0001, 1'b1, 17'h00001, 17'h10001);
        test_back_to_back();
        test_stall();
        test_reset_in_correct();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
